// File: rtl/binary_to_gray_pkg.sv
// Shared constants for Gray-coded pointer logic.
// Any block that shares the default pointer width imports this package.
package binary_to_gray_pkg;

  localparam int B2G_WIDTH_DEF = 4;
  localparam int B2G_WIDTH_MIN = 2;
  localparam int B2G_WIDTH_MAX = 32;

endpackage : binary_to_gray_pkg

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary decoder (XOR prefix from the MSB down).
// It is also usable on its own in FIFO pointer synchronisers.
module gray_to_binary
  import binary_to_gray_pkg::*;
#(
  parameter int WIDTH = B2G_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] g_i,
  output logic [WIDTH-1:0] bin_o
);

  always_comb begin
    bin_o = g_i;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin_o[i] = bin_o[i+1] ^ g_i[i];
    end
  end

endmodule : gray_to_binary

// File: rtl/binary_to_gray.sv
// Binary-to-Gray converter: combinational output plus a one-stage registered
// copy with valid flag and an optional sticky Gray->binary round-trip check.
module binary_to_gray
  import binary_to_gray_pkg::*;
#(
  parameter int WIDTH    = B2G_WIDTH_DEF,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] g,
  input  logic             in_valid,
  output logic [WIDTH-1:0] g_q,
  output logic             out_valid,
  output logic [WIDTH-1:0] b_q,
  output logic             chk_err,
  input  logic             chk_clr
);

  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             vld_q, vld_d;

  assign g = b ^ (b >> 1);

  always_comb begin
    gray_d = gray_q;
    bin_d  = bin_q;
    vld_d  = in_valid;
    if (in_valid) begin
      gray_d = g;
      bin_d  = b;
    end
  end

  // Capture stage: data holds when idle, valid drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_q <= '0;
      bin_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      gray_q <= gray_d;
      bin_q  <= bin_d;
      vld_q  <= vld_d;
    end
  end

  assign g_q       = gray_q;
  assign b_q       = bin_q;
  assign out_valid = vld_q;

  generate
    if (CHECK_EN) begin : g_chk
      logic [WIDTH-1:0] dec;
      logic             mism;
      logic             err_q, err_d;

      gray_to_binary #(.WIDTH(WIDTH)) u_dec (
        .g_i   (gray_q),
        .bin_o (dec)
      );

      assign mism = vld_q && (dec != bin_q);

      // A new mismatch takes priority over a clear in the same cycle.
      always_comb begin
        err_d = err_q;
        if (chk_clr) err_d = 1'b0;
        if (mism)    err_d = 1'b1;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
      end

      assign chk_err = err_q;
    end else begin : g_nochk
      logic unused_clr;
      assign unused_clr = chk_clr;
      assign chk_err    = 1'b0;
    end
  endgenerate

endmodule : binary_to_gray

// File: tb/tb_binary_to_gray.sv
// Self-checking bench for binary_to_gray: WIDTH=4 table and corner cases,
// WIDTH=8 randomized run against a behavioural reference.
module tb_binary_to_gray;

  typedef struct {
    logic [3:0] b;
    logic [3:0] g;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] b, g, g_q, b_q;
  logic       in_valid, out_valid, chk_err, chk_clr;
  logic [7:0] b8, g8, g_q8, b_q8;
  logic       in_valid8, out_valid8, chk_err8;

  int n_checks = 0;
  int n_fails  = 0;

  vec_t       tbl[16];
  logic [3:0] obs[16];

  always #5 clk = ~clk;

  binary_to_gray #(.WIDTH(4), .CHECK_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .b(b), .g(g), .in_valid(in_valid), .g_q(g_q),
    .out_valid(out_valid), .b_q(b_q), .chk_err(chk_err), .chk_clr(chk_clr)
  );

  binary_to_gray #(.WIDTH(8), .CHECK_EN(1'b1)) dut8 (
    .clk(clk), .rst(rst), .b(b8), .g(g8), .in_valid(in_valid8), .g_q(g_q8),
    .out_valid(out_valid8), .b_q(b_q8), .chk_err(chk_err8), .chk_clr(chk_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Reference: each Gray bit is set when it differs from the next binary bit up.
  function automatic logic [7:0] ref_gray8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = (i == 7) ? v[i] : (v[i] != v[i+1]);
    end
    return r;
  endfunction

  initial begin
    tbl[0]  = '{4'd0,  4'b0000}; tbl[1]  = '{4'd1,  4'b0001};
    tbl[2]  = '{4'd2,  4'b0011}; tbl[3]  = '{4'd3,  4'b0010};
    tbl[4]  = '{4'd4,  4'b0110}; tbl[5]  = '{4'd5,  4'b0111};
    tbl[6]  = '{4'd6,  4'b0101}; tbl[7]  = '{4'd7,  4'b0100};
    tbl[8]  = '{4'd8,  4'b1100}; tbl[9]  = '{4'd9,  4'b1101};
    tbl[10] = '{4'd10, 4'b1111}; tbl[11] = '{4'd11, 4'b1110};
    tbl[12] = '{4'd12, 4'b1010}; tbl[13] = '{4'd13, 4'b1011};
    tbl[14] = '{4'd14, 4'b1001}; tbl[15] = '{4'd15, 4'b1000};

    rst = 1'b1; b = '0; in_valid = 1'b0; chk_clr = 1'b0;
    b8 = '0; in_valid8 = 1'b0;

    #2;
    chk("rst_g_q", 32'(g_q), 32'd0);
    chk("rst_b_q", 32'(b_q), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_chk_err", 32'(chk_err), 32'd0);

    // Combinational sweep while reset is still high.
    for (int i = 0; i < 16; i++) begin
      b = tbl[i].b;
      #10;
      obs[i] = g;
      chk($sformatf("sweep_g[%0d]", i), 32'(g), 32'(tbl[i].g));
    end
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("adjacency[%0d]", i),
          32'($countones(obs[i] ^ obs[(i + 1) % 16])), 32'd1);
    end

    @(negedge clk);
    rst = 1'b0;
    edge1();

    // Registered path.
    b = 4'b0110; in_valid = 1'b1;
    edge1();
    chk("reg_g_q", 32'(g_q), 32'b0101);
    chk("reg_b_q", 32'(b_q), 32'b0110);
    chk("reg_out_valid", 32'(out_valid), 32'd1);
    chk("reg_chk_err", 32'(chk_err), 32'd0);
    b = 4'b1111; in_valid = 1'b0;
    edge1();
    chk("hold_out_valid", 32'(out_valid), 32'd0);
    chk("hold_g_q", 32'(g_q), 32'b0101);
    chk("hold_b_q", 32'(b_q), 32'b0110);
    chk("allones_g", 32'(g), 32'b1000);

    // Async reset between edges.
    b = 4'b0011; in_valid = 1'b1;
    edge1();
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_g_q", 32'(g_q), 32'd0);
    chk("async_b_q", 32'(b_q), 32'd0);
    chk("async_chk_err", 32'(chk_err), 32'd0);
    b = 4'b1010;
    #1;
    chk("async_g_tracks", 32'(g), 32'b1111);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    edge1();

    // Checker: corrupt the Gray register.
    b = 4'b0011; in_valid = 1'b1;
    edge1();
    chk("chk_clean", 32'(chk_err), 32'd0);
    force dut.gray_q = 4'b0011;
    edge1();
    chk("chk_set", 32'(chk_err), 32'd1);
    release dut.gray_q;
    edge1();
    chk("chk_held", 32'(chk_err), 32'd1);
    chk("chk_gq_restored", 32'(g_q), 32'b0010);
    chk_clr = 1'b1;
    edge1();
    chk_clr = 1'b0;
    chk("chk_cleared", 32'(chk_err), 32'd0);
    force dut.gray_q = 4'b0011;
    edge1();
    chk("chk_set2", 32'(chk_err), 32'd1);
    chk_clr = 1'b1;
    edge1();
    chk("chk_set_wins", 32'(chk_err), 32'd1);
    release dut.gray_q;
    edge1();
    edge1();
    chk("chk_cleared2", 32'(chk_err), 32'd0);
    chk_clr = 1'b0;
    in_valid = 1'b0;

    // WIDTH=8 randomized run.
    begin
      logic [7:0] vb;
      logic       viv;
      logic [7:0] exp_gq, exp_bq;
      exp_gq = g_q8;
      exp_bq = b_q8;
      for (int k = 0; k < 1000; k++) begin
        @(negedge clk);
        vb  = 8'($urandom);
        viv = ($urandom_range(0, 3) != 0);
        b8 = vb; in_valid8 = viv;
        #1;
        chk("rnd_g8", 32'(g8), 32'(ref_gray8(vb)));
        if (viv) begin
          exp_gq = ref_gray8(vb);
          exp_bq = vb;
        end
        edge1();
        chk("rnd_out_valid8", 32'(out_valid8), 32'(viv));
        chk("rnd_g_q8", 32'(g_q8), 32'(exp_gq));
        chk("rnd_b_q8", 32'(b_q8), 32'(exp_bq));
        chk("rnd_chk_err8", 32'(chk_err8), 32'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_binary_to_gray
